he_lb_csr_sequencer: RTL and testbench

Sequences one HE-LB loopback run over an MMIO master port. It programs the exerciser CSRs (soft reset, DSM base, source/destination, line count, config), starts the run, polls STATUS0 until completion, stops the engine and reads ERROR. It sits between a test/host-side command source and the MMIO request path of the HE-LB AFU in the unit-test and self-test environments.

---
 rtl/he_lb_csr_sequencer.sv | 236 +++++++++++++++++++++++
 tb/tb_he_lb_csr_sequencer.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/he_lb_csr_sequencer.sv
// he_lb_csr_sequencer
//   Drives one HE-LB loopback run over a 64-bit MMIO master port: soft reset,
//   CSR programming, start, STATUS0 polling, engine stop and ERROR read-back.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   start                      launch pulse (accepted only when idle)
//   abort                      level request to stop the run early
//   cfg_*                      run configuration, captured on accepted start
//   req_valid/ready/write/addr/wdata   MMIO request channel (valid/ready)
//   rsp_valid/rsp_rdata        MMIO read-response channel (single-cycle pulse)
//   busy, done                 run in progress / one-cycle completion pulse
//   timeout, aborted           sticky run status, cleared on accepted start
//   err_code                   last ERROR CSR value read
//   poll_count                 STATUS0 reads issued in this run (saturating)
module he_lb_csr_sequencer #(
    parameter int unsigned POLL_GAP   = 16,
    parameter int unsigned POLL_LIMIT = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [63:0] cfg_dsm_base,
    input  logic [63:0] cfg_src_addr,
    input  logic [63:0] cfg_dst_addr,
    input  logic [31:0] cfg_num_lines,
    input  logic [63:0] cfg_cfg,
    input  logic [31:0] cfg_expect,
    output logic        req_valid,
    input  logic        req_ready,
    output logic        req_write,
    output logic [15:0] req_addr,
    output logic [63:0] req_wdata,
    input  logic        rsp_valid,
    input  logic [63:0] rsp_rdata,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic        aborted,
    output logic [63:0] err_code,
    output logic [15:0] poll_count
);

    localparam logic [15:0] ADDR_DSM    = 16'h0110;
    localparam logic [15:0] ADDR_SRC    = 16'h0120;
    localparam logic [15:0] ADDR_DST    = 16'h0128;
    localparam logic [15:0] ADDR_LINES  = 16'h0130;
    localparam logic [15:0] ADDR_CTL    = 16'h0138;
    localparam logic [15:0] ADDR_CFG    = 16'h0140;
    localparam logic [15:0] ADDR_STATUS = 16'h0160;
    localparam logic [15:0] ADDR_ERROR  = 16'h0170;

    localparam int unsigned GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(POLL_GAP - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_W_RST, S_W_REL, S_W_DSM, S_W_SRC, S_W_DST, S_W_LINES,
        S_W_CFG, S_W_GO, S_P_GAP, S_P_REQ, S_P_RSP, S_W_STOP, S_E_REQ,
        S_E_RSP, S_FIN
    } state_e;

    state_e state_q, state_d;

    logic [63:0]      dsm_q, dsm_d, src_q, src_d, dst_q, dst_d, cfg_q, cfg_d;
    logic [31:0]      lines_q, lines_d, expect_q, expect_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [15:0]      poll_q, poll_d;
    logic [63:0]      err_q, err_d;
    logic             timeout_q, timeout_d, aborted_q, aborted_d;

    logic abort_window;
    logic stop_early;
    logic poll_match;
    logic poll_exhausted;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Run datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dsm_q     <= '0;
            src_q     <= '0;
            dst_q     <= '0;
            cfg_q     <= '0;
            lines_q   <= '0;
            expect_q  <= '0;
            gap_q     <= '0;
            poll_q    <= '0;
            err_q     <= '0;
            timeout_q <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            dsm_q     <= dsm_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            cfg_q     <= cfg_d;
            lines_q   <= lines_d;
            expect_q  <= expect_d;
            gap_q     <= gap_d;
            poll_q    <= poll_d;
            err_q     <= err_d;
            timeout_q <= timeout_d;
            aborted_q <= aborted_d;
        end
    end

    // Abort is honoured from the first setup write until the poll response.
    // aborted_q doubles as the pending-stop flag, so a short abort pulse seen
    // while a handshake is stalled still diverts the run once it completes.
    assign abort_window   = (state_q >= S_W_RST) && (state_q <= S_P_RSP);
    assign stop_early     = abort || aborted_q;
    assign poll_match     = (rsp_rdata[31:0] == expect_q);
    assign poll_exhausted = ({16'd0, poll_q} >= 32'(POLL_LIMIT));

    // Next-state and datapath update
    always_comb begin
        state_d   = state_q;
        dsm_d     = dsm_q;
        src_d     = src_q;
        dst_d     = dst_q;
        cfg_d     = cfg_q;
        lines_d   = lines_q;
        expect_d  = expect_q;
        gap_d     = '0;
        poll_d    = poll_q;
        err_d     = err_q;
        timeout_d = timeout_q;
        aborted_d = aborted_q | (abort & abort_window);

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_W_RST;
                    dsm_d     = cfg_dsm_base;
                    src_d     = cfg_src_addr;
                    dst_d     = cfg_dst_addr;
                    cfg_d     = cfg_cfg;
                    lines_d   = cfg_num_lines;
                    expect_d  = cfg_expect;
                    poll_d    = '0;
                    timeout_d = 1'b0;
                    aborted_d = 1'b0;
                end
            end
            S_W_RST:   if (req_ready) state_d = stop_early ? S_W_STOP : S_W_REL;
            S_W_REL:   if (req_ready) state_d = stop_early ? S_W_STOP : S_W_DSM;
            S_W_DSM:   if (req_ready) state_d = stop_early ? S_W_STOP : S_W_SRC;
            S_W_SRC:   if (req_ready) state_d = stop_early ? S_W_STOP : S_W_DST;
            S_W_DST:   if (req_ready) state_d = stop_early ? S_W_STOP : S_W_LINES;
            S_W_LINES: if (req_ready) state_d = stop_early ? S_W_STOP : S_W_CFG;
            S_W_CFG:   if (req_ready) state_d = stop_early ? S_W_STOP : S_W_GO;
            S_W_GO:    if (req_ready) state_d = stop_early ? S_W_STOP : S_P_GAP;
            S_P_GAP: begin
                if (stop_early) begin
                    state_d = S_W_STOP;
                end else if (gap_q == GAP_LAST) begin
                    state_d = S_P_REQ;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            S_P_REQ: begin
                if (req_ready) begin
                    state_d = S_P_RSP;
                    poll_d  = (poll_q == 16'hFFFF) ? poll_q : poll_q + 16'd1;
                end
            end
            S_P_RSP: begin
                if (rsp_valid) begin
                    if (poll_match) begin
                        state_d = S_W_STOP;
                    end else if (poll_exhausted) begin
                        state_d   = S_W_STOP;
                        timeout_d = 1'b1;
                    end else if (stop_early) begin
                        state_d = S_W_STOP;
                    end else begin
                        state_d = S_P_GAP;
                    end
                end
            end
            S_W_STOP:  if (req_ready) state_d = S_E_REQ;
            S_E_REQ:   if (req_ready) state_d = S_E_RSP;
            S_E_RSP: begin
                if (rsp_valid) begin
                    state_d = S_FIN;
                    err_d   = rsp_rdata;
                end
            end
            S_FIN:     state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = '0;
        req_wdata = '0;

        unique case (state_q)
            S_W_RST:   begin req_addr = ADDR_CTL;   req_wdata = 64'd0;              end
            S_W_REL:   begin req_addr = ADDR_CTL;   req_wdata = 64'd1;              end
            S_W_DSM:   begin req_addr = ADDR_DSM;   req_wdata = dsm_q;              end
            S_W_SRC:   begin req_addr = ADDR_SRC;   req_wdata = src_q;              end
            S_W_DST:   begin req_addr = ADDR_DST;   req_wdata = dst_q;              end
            S_W_LINES: begin req_addr = ADDR_LINES; req_wdata = {32'd0, lines_q};   end
            S_W_CFG:   begin req_addr = ADDR_CFG;   req_wdata = cfg_q;              end
            S_W_GO:    begin req_addr = ADDR_CTL;   req_wdata = 64'd3;              end
            S_W_STOP:  begin req_addr = ADDR_CTL;   req_wdata = 64'd1;              end
            S_P_REQ:   begin req_addr = ADDR_STATUS; req_write = 1'b0;              end
            S_E_REQ:   begin req_addr = ADDR_ERROR;  req_write = 1'b0;              end
            default: begin
                req_valid = 1'b0;
                req_write = 1'b0;
            end
        endcase

        busy       = (state_q != S_IDLE) && (state_q != S_FIN);
        done       = (state_q == S_FIN);
        timeout    = timeout_q;
        aborted    = aborted_q;
        err_code   = err_q;
        poll_count = poll_q;
    end

endmodule

// File: tb/tb_he_lb_csr_sequencer.sv
// tb_he_lb_csr_sequencer
//   Scoreboard bench for he_lb_csr_sequencer. Each run's expected MMIO
//   transaction list and final status are derived from the run's
//   configuration and the STATUS0 values the responder will return, pushed
//   into queues, and checked by an independent monitor at every handshake
//   and every done pulse.
module tb_he_lb_csr_sequencer;

    localparam int unsigned GAP = 3;
    localparam int unsigned LIM = 4;

    logic        clk = 1'b0;
    logic        rst_n, start, abort;
    logic [63:0] cfg_dsm_base, cfg_src_addr, cfg_dst_addr, cfg_cfg;
    logic [31:0] cfg_num_lines, cfg_expect;
    logic        req_valid, req_ready, req_write;
    logic [15:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic        busy, done, timeout, aborted;
    logic [63:0] err_code;
    logic [15:0] poll_count;

    he_lb_csr_sequencer #(.POLL_GAP(GAP), .POLL_LIMIT(LIM)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cfg_dsm_base(cfg_dsm_base), .cfg_src_addr(cfg_src_addr),
        .cfg_dst_addr(cfg_dst_addr), .cfg_num_lines(cfg_num_lines),
        .cfg_cfg(cfg_cfg), .cfg_expect(cfg_expect),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .busy(busy), .done(done), .timeout(timeout), .aborted(aborted),
        .err_code(err_code), .poll_count(poll_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        w;
        logic [15:0] a;
        logic [63:0] d;
    } txn_t;

    typedef struct packed {
        logic [15:0] pc;
        logic        to;
        logic        ab;
        logic [63:0] err;
    } res_t;

    txn_t        exp_q[$];
    res_t        res_q[$];
    logic [63:0] stat_q[$];

    int total = 0;
    int bad   = 0;
    int cycle = 0;
    int rd_cnt = 0;
    int done_cnt = 0;
    int go_cyc = 0;
    bit first_rd_pend = 1'b0;
    int ready_mode = 0;
    int rsp_lat = 2;
    logic [63:0] err_val = '0;
    bit   hold_pend = 1'b0;
    txn_t hold_val;

    // Ready generator: always, one cycle in three, or random
    initial begin
        int rc = 0;
        req_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       req_ready = 1'b1;
                1:       req_ready = (rc % 3 == 0);
                default: req_ready = 1'($urandom % 2);
            endcase
            rc++;
        end
    end

    // Read responder: one pulse rsp_lat cycles after each read handshake
    initial begin
        logic [15:0] a;
        rsp_valid = 1'b0;
        rsp_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst_n && req_valid && req_ready && !req_write) begin
                a = req_addr;
                @(posedge clk);
                repeat (rsp_lat - 1) @(posedge clk);
                #1;
                if (a == 16'h0160)
                    rsp_rdata = (stat_q.size() != 0) ? stat_q.pop_front() : {$urandom, 32'd0};
                else
                    rsp_rdata = err_val;
                rsp_valid = 1'b1;
                @(posedge clk);
                #1;
                rsp_valid = 1'b0;
                rsp_rdata = {$urandom, $urandom};
            end
        end
    end

    // Monitor / scoreboard checker
    always @(negedge clk) begin
        txn_t cur, e;
        res_t got, want;
        cycle++;
        if (!rst_n) begin
            hold_pend     = 1'b0;
            first_rd_pend = 1'b0;
        end else begin
            cur = {req_write, req_addr, req_wdata};
            if (hold_pend && req_valid) begin
                total++;
                if (cur != hold_val) begin
                    bad++;
                    $display("FAIL hold_stable got=%h want=%h", cur, hold_val);
                end
            end
            hold_pend = req_valid && !req_ready;
            hold_val  = cur;

            if (req_valid && !req_write && req_addr == 16'h0160 && first_rd_pend) begin
                total++;
                if (cycle != go_cyc + int'(GAP) + 1) begin
                    bad++;
                    $display("FAIL first_poll_gap got=%0d want=%0d", cycle - go_cyc, GAP + 1);
                end
                first_rd_pend = 1'b0;
            end

            if (req_valid && req_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_req got w=%0b a=%h d=%h want none", req_write, req_addr, req_wdata);
                end else begin
                    e = exp_q.pop_front();
                    if (e.w != req_write || e.a != req_addr || (e.w && e.d != req_wdata)) begin
                        bad++;
                        $display("FAIL req_txn got w=%0b a=%h d=%h want w=%0b a=%h d=%h",
                                 req_write, req_addr, req_wdata, e.w, e.a, e.d);
                    end
                end
                if (!req_write && req_addr == 16'h0160) rd_cnt++;
                if (req_write && req_addr == 16'h0138 && req_wdata == 64'd3) begin
                    go_cyc        = cycle;
                    first_rd_pend = 1'b1;
                end
            end

            if (done) begin
                total++;
                got = {poll_count, timeout, aborted, err_code};
                if (res_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_done got=%h want none", got);
                end else begin
                    want = res_q.pop_front();
                    if (got != want || busy) begin
                        bad++;
                        $display("FAIL run_result got pc=%0d to=%0b ab=%0b err=%h busy=%0b want pc=%0d to=%0b ab=%0b err=%h busy=0",
                                 poll_count, timeout, aborted, err_code, busy, want.pc, want.to, want.ab, want.err);
                    end
                end
                done_cnt++;
            end
        end
    end

    function automatic txn_t mk(input logic w, input logic [15:0] a, input logic [63:0] d);
        mk = {w, a, d};
    endfunction

    // Reference model: the whole run's transactions from the configuration,
    // the queued STATUS0 values, and the abort point.
    task automatic build_expect(input logic [31:0] expv, input logic [63:0] errv, input int abort_after);
        logic [63:0] v;
        bit   stop = 1'b0;
        bit   to = 1'b0;
        bit   ab = 1'b0;
        int   n = 0;
        exp_q.push_back(mk(1'b1, 16'h0138, 64'd0));
        exp_q.push_back(mk(1'b1, 16'h0138, 64'd1));
        exp_q.push_back(mk(1'b1, 16'h0110, cfg_dsm_base));
        exp_q.push_back(mk(1'b1, 16'h0120, cfg_src_addr));
        exp_q.push_back(mk(1'b1, 16'h0128, cfg_dst_addr));
        exp_q.push_back(mk(1'b1, 16'h0130, {32'd0, cfg_num_lines}));
        exp_q.push_back(mk(1'b1, 16'h0140, cfg_cfg));
        exp_q.push_back(mk(1'b1, 16'h0138, 64'd3));
        while (!stop) begin
            n++;
            exp_q.push_back(mk(1'b0, 16'h0160, 64'd0));
            v = (n <= stat_q.size()) ? stat_q[n-1] : 64'd0;
            if (v[31:0] == expv) stop = 1'b1;
            else if (n >= int'(LIM)) begin to = 1'b1; stop = 1'b1; end
            else if (abort_after != 0 && n >= abort_after) begin ab = 1'b1; stop = 1'b1; end
        end
        exp_q.push_back(mk(1'b1, 16'h0138, 64'd1));
        exp_q.push_back(mk(1'b0, 16'h0170, 64'd0));
        res_q.push_back({16'(n), to, ab, errv});
    endtask

    task automatic rand_cfg(input bit zero_lines);
        cfg_dsm_base  = {$urandom, $urandom};
        cfg_src_addr  = {$urandom, $urandom};
        cfg_dst_addr  = {$urandom, $urandom};
        cfg_cfg       = {$urandom, $urandom};
        cfg_num_lines = (zero_lines || ($urandom % 4 == 0)) ? 32'd0 : $urandom;
    endtask

    task automatic launch(input int mode, input int lat, input logic [31:0] expv,
                          input logic [63:0] errv, input int abort_after, input bit zero_lines);
        ready_mode = mode;
        rsp_lat    = lat;
        err_val    = errv;
        rand_cfg(zero_lines);
        cfg_expect = expv;
        build_expect(expv, errv, abort_after);
        rd_cnt = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        total++;
        if (!(busy && req_valid && req_write && req_addr == 16'h0138)) begin
            bad++;
            $display("FAIL start_latency got busy=%0b valid=%0b addr=%h want busy=1 valid=1 addr=0138",
                     busy, req_valid, req_addr);
        end
    endtask

    task automatic finish_run(input int prev_done);
        bit seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(posedge clk);
            if (done_cnt != prev_done) seen = 1'b1;
        end
        #1 abort = 1'b0;
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL done_wait got no done want done within 3000 cycles");
        end
        total++;
        if (exp_q.size() != 0 || res_q.size() != 0) begin
            bad++;
            $display("FAIL leftover got txns=%0d results=%0d want 0 0", exp_q.size(), res_q.size());
        end
        exp_q.delete();
        res_q.delete();
        stat_q.delete();
        repeat (2) @(posedge clk);
    endtask

    task automatic do_run(input int mode, input int lat, input logic [31:0] expv,
                          input logic [63:0] errv, input int abort_after,
                          input bit midstart, input bit zero_lines);
        int prev = done_cnt;
        bit reached = 1'b0;
        launch(mode, lat, expv, errv, abort_after, zero_lines);
        if (midstart) begin
            @(posedge clk); #1;
            rand_cfg(1'b0);
            cfg_expect = ~expv;
            start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end
        if (abort_after != 0) begin
            for (int i = 0; i < 2000 && !reached; i++) begin
                @(posedge clk);
                if (rd_cnt >= abort_after) reached = 1'b1;
            end
            #1 abort = 1'b1;
            total++;
            if (!reached) begin
                bad++;
                $display("FAIL abort_wait got reads=%0d want %0d", rd_cnt, abort_after);
            end
        end
        finish_run(prev);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] outs;
        bit found = 1'b0;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        cfg_dsm_base = '0; cfg_src_addr = '0; cfg_dst_addr = '0;
        cfg_cfg = '0; cfg_num_lines = '0; cfg_expect = '0;
        #2;
        total++;
        if ({req_valid, req_write, req_addr, req_wdata, busy, done, timeout, aborted, err_code, poll_count} != '0) begin
            bad++;
            $display("FAIL reset_state got nonzero outputs want all zero");
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Nominal: STATUS0 returns 5 then 8, expect 8, ERROR 0
        stat_q.push_back({$urandom, 32'd5});
        stat_q.push_back({$urandom, 32'd8});
        do_run(0, 2, 32'd8, 64'd0, 0, 1'b0, 1'b0);

        // Backpressure, same scenario
        stat_q.push_back({$urandom, 32'd5});
        stat_q.push_back({$urandom, 32'd8});
        do_run(1, 2, 32'd8, 64'd0, 0, 1'b0, 1'b0);

        // Timeout: STATUS0 never matches
        do_run(0, 2, 32'd1, {$urandom, $urandom}, 0, 1'b0, 1'b0);

        // Abort after the second read is issued
        do_run(0, 3, 32'd1, {$urandom, $urandom}, 2, 1'b0, 1'b0);

        // Start while busy plus config change; statuses from earlier runs must clear
        stat_q.push_back({$urandom, 32'd7});
        do_run(0, 1, 32'd7, {$urandom, $urandom}, 0, 1'b1, 1'b0);

        // expect=0 with zero line count: first poll matches
        do_run(2, 2, 32'd0, {$urandom, $urandom}, 0, 1'b0, 1'b1);

        // Reset while the DST write is being presented
        launch(1, 2, 32'd0, 64'd5, 0, 1'b0);
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (req_valid && req_addr == 16'h0128) found = 1'b1;
        end
        #2 rst_n = 1'b0;
        #1;
        outs = {req_valid, req_write, req_wdata[30:0], busy, done, timeout, aborted, poll_count, req_addr};
        total++;
        if (!found || outs != '0 || err_code != '0 || req_wdata != '0) begin
            bad++;
            $display("FAIL reset_mid_run got found=%0b valid=%0b addr=%h busy=%0b err=%h want found=1 all zero",
                     found, req_valid, req_addr, busy, err_code);
        end
        exp_q.delete();
        res_q.delete();
        stat_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        stat_q.push_back({$urandom, 32'd9});
        do_run(0, 2, 32'd9, {$urandom, $urandom}, 0, 1'b0, 1'b0);

        // Randomized runs
        for (int r = 0; r < 12; r++) begin
            int k = $urandom % 6;
            for (int j = 0; j < k; j++) stat_q.push_back({$urandom, 32'($urandom % 3)});
            do_run($urandom % 3, 1 + $urandom % 4, 32'($urandom % 3), {$urandom, $urandom},
                   0, 1'($urandom % 2), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
